rr_arbiter_n: RTL and testbench
===============================

Name: rr_arbiter_n

Overview:
- Parametrised N-requester round-robin arbiter with registered one-hot grant and a bounded grant-hold quantum.
- Sits in front of any shared resource in the pipeline, such as a memory port or a writeback bus, that has more than two clients.
- Grants are a function of this cycle's requests and appear one cycle later.
- A granted requester keeps the grant for up to MAX_HOLD consecutive cycles while others wait; the grant then rotates.

Parameters:
- N, 4, number of requesters; must be >= 2.
- MAX_HOLD, 4, maximum consecutive cycles one requester may hold the grant while another requester is waiting; must be >= 1. MAX_HOLD=1 gives strict per-cycle alternation.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  N  request vector; bit i = requester i.
- lock  input  N  per-requester grant lock; used only when ARB_LOCK_EN is defined, otherwise ignored.
- grant  output  N  registered one-hot grant; all-zero when idle.
- grant_valid  output  1  registered; 1 when grant is non-zero.
- grant_idx  output  clog2(N)  registered binary index of the granted requester; 0 when idle.

Behaviour:
- Internal state:
  - ptr: index of the last winner, clog2(N) bits.
  - hold_cnt: consecutive cycles the current grant has been held, clog2(MAX_HOLD+1) bits, saturating.
- Reset (reset_n=0, takes effect immediately, asynchronous):
  - grant=0, grant_valid=0, grant_idx=0, hold_cnt=0.
  - ptr=N-1, so requester 0 has first priority after reset.
- Latency: the req sampled at edge k determines grant at k+1. No combinational path from req to any output.
- Per-cycle decision, first matching rule wins. cur = grant_idx when grant_valid=1.
  1. Keep: grant_valid=1, req[cur]=1, and (hold_cnt < MAX_HOLD-1, or no other req bit set) -> grant unchanged, hold_cnt+1 (saturating), ptr unchanged.
  2. Rotate: any req bit set -> winner is the first set bit scanning ptr+1, ptr+2, ... ptr+N (mod N). Then grant=onehot(winner), grant_idx=winner, grant_valid=1, ptr=winner, hold_cnt=0. The scan includes ptr itself last, so a lone requester always wins.
  3. Idle: req=0 -> grant=0, grant_valid=0, grant_idx=0, hold_cnt=0, ptr retained.
- Boundary cases:
  - Current holder drops req mid-quantum: rotate next cycle, scanning from cur+1. The quantum does not carry over.
  - Single persistent requester: holds the grant indefinitely. hold_cnt saturates at MAX_HOLD and never wraps.
  - ptr wraps N-1 -> 0.
  - N not a power of two: indices >= N are never produced.
  - Simultaneous quantum expiry and new requests: normal rotation, with no skipped requester.
  - Reset mid-grant: outputs clear asynchronously. The first post-reset grant goes to the lowest set req index.
- Invariant checked by bench: grant is one-hot or zero; grant_valid == |grant; grant_idx matches grant.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - In rule 1, if lock[cur]=1 and req[cur]=1, the grant is kept regardless of hold_cnt and other requests. hold_cnt still saturates.
  - lock of non-granted requesters is ignored.
  - When lock[cur] drops, the normal quantum test applies on the next decision. If hold_cnt >= MAX_HOLD-1 and others are waiting, the grant rotates immediately.
- Undefined: lock is ignored entirely; behaviour is exactly as above.

Test Plan:
1. N=4, MAX_HOLD=2; release reset, req=4'b1111 held -> grant from the next cycle: 0001,0001,0010,0010,0100,0100,1000,1000,0001. grant_idx tracks 0,0,1,1,2,2,3,3,0.
2. req=4'b0100 held 10 cycles -> grant=0100, grant_idx=2, grant_valid=1 every cycle; no rotation.
3. req=0110 for one cycle (grant 0010 follows), then req=0100 -> next grant 0100 with hold restarted. req=0110 again -> 0100 held one more cycle, then 0010.
4. After requester 2 wins, req=0 for 3 cycles -> grant=0, grant_valid=0. Then req=1111 -> grant=1000, since ptr was retained at 2.
5. Pull reset_n low mid-way through scenario 1 -> grant/grant_valid/grant_idx drop to 0 before the next clock edge. Release with req=1111 -> grant=0001.
6. ARB_LOCK_EN defined, MAX_HOLD=2, req=1111, lock=0010 once requester 1 is granted -> grant 0010 held 6 cycles. Drop lock -> next grant 0100.

Source files
------------

// File: rtl/rr_arbiter_n.sv
// N-way round-robin arbiter with registered one-hot grant and a MAX_HOLD grant quantum.
// Latency: req at edge k is reflected in grant at k+1. There is no combinational req->output path.
// Backpressure: requesters wait while they are not granted. Define ARB_LOCK_EN to let the holder pin its grant.
module rr_arbiter_n #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         lock,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_idx
);
    localparam int IDX_W = $clog2(N);
    localparam int HC_W  = $clog2(MAX_HOLD + 1);
    localparam logic [HC_W-1:0]  HOLD_MAX = HC_W'(MAX_HOLD);
    localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(N - 1);

    logic [IDX_W-1:0] ptr;
    logic [HC_W-1:0]  hold_cnt;
    logic [IDX_W-1:0] win;
    logic             others_waiting;
    logic             lock_hold;
    logic             keep;

`ifdef ARB_LOCK_EN
    assign lock_hold = lock[grant_idx];
`else
    logic unused_lock;
    assign unused_lock = ^lock;
    assign lock_hold   = 1'b0;
`endif

    assign others_waiting = |(req & ~grant);
    assign keep = grant_valid && req[grant_idx] &&
                  (lock_hold || (int'(hold_cnt) < MAX_HOLD - 1) || !others_waiting);

    // The scan starts just after the last winner and visits ptr itself last.
    always_comb begin
        logic found;
        int   idx;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            hold_cnt    <= '0;
            ptr         <= PTR_RST;
        end else if (keep) begin
            if (hold_cnt != HOLD_MAX)
                hold_cnt <= hold_cnt + HC_W'(1);
        end else if (|req) begin
            grant       <= N'(1) << win;
            grant_valid <= 1'b1;
            grant_idx   <= win;
            ptr         <= win;
            hold_cnt    <= '0;
        end else begin
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            hold_cnt    <= '0;
        end
    end
endmodule

// File: tb/tb_rr_arbiter_n.sv
// Directed bench for rr_arbiter_n: a 4-way MAX_HOLD=2 instance and a 3-way MAX_HOLD=1 instance.
module tb_rr_arbiter_n;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [3:0] req, lock, grant;
    logic       grant_valid;
    logic [1:0] grant_idx;

    logic [2:0] req3, lock3, grant3;
    logic       grant_valid3;
    logic [1:0] grant_idx3;

    int checks   = 0;
    int failures = 0;

    rr_arbiter_n #(.N(4), .MAX_HOLD(2)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .lock(lock),
        .grant(grant), .grant_valid(grant_valid), .grant_idx(grant_idx)
    );

    rr_arbiter_n #(.N(3), .MAX_HOLD(1)) dut3 (
        .clk(clk), .reset_n(reset_n), .req(req3), .lock(lock3),
        .grant(grant3), .grant_valid(grant_valid3), .grant_idx(grant_idx3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Compares the 4-way instance's outputs against one expected grant (index derived from it).
    task automatic expect4(input string name, input int step, input logic [3:0] eg);
        logic [1:0] ei;
        ei = 2'd0;
        for (int b = 0; b < 4; b++) if (eg[b]) ei = 2'(b);
        checks++;
        if (grant !== eg || grant_valid !== (|eg) || grant_idx !== ei) begin
            failures++;
            $display("FAIL %s step %0d: grant=%b valid=%b idx=%0d, required grant=%b valid=%b idx=%0d",
                     name, step, grant, grant_valid, grant_idx, eg, |eg, ei);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; req = '0; lock = '0; req3 = '0; lock3 = '0;
        #3;
        checks++;
        if (grant !== 4'b0 || grant_valid !== 1'b0 || grant_idx !== 2'd0 ||
            grant3 !== 3'b0 || grant_valid3 !== 1'b0 || grant_idx3 !== 2'd0) begin
            failures++;
            $display("FAIL reset: grant=%b valid=%b idx=%0d grant3=%b, required all zero",
                     grant, grant_valid, grant_idx, grant3);
        end
        tick; tick;
        reset_n = 1'b1;
        tick;
        expect4("reset_idle", 0, 4'b0000);
    endtask

    task automatic test_rotate;
        logic [3:0] exp_g [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                                  4'b0100, 4'b1000, 4'b1000, 4'b0001};
        logic [1:0] exp_i [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        req = 4'b1111;
        for (int i = 0; i < 9; i++) begin
            tick;
            checks++;
            if (grant !== exp_g[i] || grant_idx !== exp_i[i] || grant_valid !== 1'b1) begin
                failures++;
                $display("FAIL rotate step %0d: grant=%b idx=%0d valid=%b, required grant=%b idx=%0d valid=1",
                         i, grant, grant_idx, grant_valid, exp_g[i], exp_i[i]);
            end
        end
    endtask

    task automatic test_single;
        req = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            tick;
            expect4("single", i, 4'b0100);
        end
    endtask

    task automatic test_drop;
        logic [3:0] stim [4] = '{4'b0110, 4'b0100, 4'b0110, 4'b0110};
        logic [3:0] exp_g [4] = '{4'b0010, 4'b0100, 4'b0100, 4'b0010};
        for (int i = 0; i < 4; i++) begin
            req = stim[i];
            tick;
            expect4("drop", i, exp_g[i]);
        end
    endtask

    task automatic test_idle;
        logic [3:0] stim [7] = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b1111};
        logic [3:0] exp_g [7] = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0001};
        for (int i = 0; i < 7; i++) begin
            req = stim[i];
            tick;
            expect4("idle", i, exp_g[i]);
        end
    endtask

    task automatic test_reset_mid;
        req = 4'b1111;
        tick; tick;
        checks++;
        if (grant_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_pre: valid=%b, required 1", grant_valid);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (grant !== 4'b0 || grant_valid !== 1'b0 || grant_idx !== 2'd0) begin
            failures++;
            $display("FAIL reset_mid_async: grant=%b valid=%b idx=%0d, required all zero",
                     grant, grant_valid, grant_idx);
        end
        tick;
        expect4("reset_mid_held", 0, 4'b0000);
        @(negedge clk);
        reset_n = 1'b1;
        tick;
        expect4("reset_mid_first", 0, 4'b0001);
    endtask

    task automatic test_lock;
        reset_n = 1'b0; req = '0; lock = '0;
        tick;
        @(negedge clk);
        reset_n = 1'b1;
        req = 4'b1111;
`ifdef ARB_LOCK_EN
        tick; expect4("lock_pre", 0, 4'b0001);
        tick; expect4("lock_pre", 1, 4'b0001);
        tick; expect4("lock_pre", 2, 4'b0010);
        lock = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            tick;
            expect4("lock_hold", i, 4'b0010);
        end
        lock = 4'b0000;
        tick;
        expect4("lock_release", 0, 4'b0100);
`else
        lock = 4'b1111;
        tick; expect4("lock_ignored", 0, 4'b0001);
        tick; expect4("lock_ignored", 1, 4'b0001);
        tick; expect4("lock_ignored", 2, 4'b0010);
        tick; expect4("lock_ignored", 3, 4'b0010);
        tick; expect4("lock_ignored", 4, 4'b0100);
        lock = 4'b0000;
`endif
    endtask

    task automatic test_n3;
        logic [2:0] stim [8]  = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b100, 3'b100, 3'b101, 3'b101};
        logic [2:0] exp_g [8] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b100, 3'b100, 3'b001, 3'b100};
        logic [1:0] exp_i [8] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd2, 2'd2, 2'd0, 2'd2};
        req = '0;
        for (int i = 0; i < 8; i++) begin
            req3 = stim[i];
            tick;
            checks++;
            if (grant3 !== exp_g[i] || grant_idx3 !== exp_i[i] || grant_valid3 !== 1'b1) begin
                failures++;
                $display("FAIL n3 step %0d: grant=%b idx=%0d valid=%b, required grant=%b idx=%0d valid=1",
                         i, grant3, grant_idx3, grant_valid3, exp_g[i], exp_i[i]);
            end
        end
        req3 = '0;
        tick;
        checks++;
        if (grant3 !== 3'b0 || grant_valid3 !== 1'b0 || grant_idx3 !== 2'd0) begin
            failures++;
            $display("FAIL n3_idle: grant=%b valid=%b idx=%0d, required all zero",
                     grant3, grant_valid3, grant_idx3);
        end
    endtask

    initial begin
        test_reset;
        test_rotate;
        test_single;
        test_drop;
        test_idle;
        test_reset_mid;
        test_lock;
        test_n3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
